// File: rtl/boot_pkg.sv
// Shared definitions for boot image selection: image indices, flash layout and FSM encoding.
// Imported by boot_target_select.
package boot_pkg;

  localparam logic [2:0] IMG_LOADER  = 3'd0;
  localparam logic [2:0] IMG_UNKNOWN = 3'd1;
  localparam logic [2:0] IMG_6502    = 3'd2;
  localparam logic [2:0] IMG_Z80     = 3'd3;
  localparam logic [2:0] IMG_65C02   = 3'd4;

  localparam logic [23:0] IMAGE_STRIDE = 24'h054000;
  // Upper byte of GENERAL_2 that the downstream sequencer pairs with boot_addr.
  localparam logic [7:0]  ICAP_READ_OP = 8'h03;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_LATCH   = 3'd1,
    ST_REQUEST = 3'd2,
    ST_DONE    = 3'd3
  } state_t;

  // Pin word is {mode, id[3:0]}; the loader image is never selected here.
  function automatic logic [2:0] decode_pins(input logic [4:0] pins);
    logic [2:0] sel;
    sel = IMG_UNKNOWN;
    if (pins == 5'b11110) begin
      sel = IMG_6502;
    end else if (pins[3:0] == 4'b1101) begin
      sel = IMG_Z80;
    end else if (pins == 5'b01110) begin
      sel = IMG_65C02;
    end
    return sel;
  endfunction

  // sel * IMAGE_STRIDE as shift-and-add; sel <= 4 cannot overflow 24 bits.
  function automatic logic [23:0] image_addr(input logic [2:0] sel);
    logic [23:0] addr;
    addr = 24'd0;
    if (sel[0]) addr = addr + IMAGE_STRIDE;
    if (sel[1]) addr = addr + (IMAGE_STRIDE << 1);
    if (sel[2]) addr = addr + (IMAGE_STRIDE << 2);
    return addr;
  endfunction

endpackage

// File: rtl/pin_sync2.sv
// Two-flop synchroniser for asynchronous input pins; both stages reset to 0.
// Latency 2 clocks.
module pin_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_target_select.sv
// Debounces adapter-identity pins, decodes a boot image index and flash address, and
// offers the result once over valid/ready; DONE is terminal until reset.
module boot_target_select
  import boot_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV      = 256,
  parameter int unsigned STABLE_COUNT    = 16,
  parameter int unsigned TIMEOUT_SAMPLES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode_in,
  input  logic [3:0]  id_in,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [2:0]  boot_sel,
  output logic [23:0] boot_addr,
  output logic        timed_out,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STB_W = $clog2(STABLE_COUNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_SAMPLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SAMPLE_DIV - 1);
  localparam logic [STB_W-1:0] STB_LIMIT  = STB_W'(STABLE_COUNT);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_SAMPLES);

  state_t state, state_nxt;

  logic [4:0]       sample;
  logic [4:0]       prev_sample;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [STB_W-1:0] stable_cnt, stable_nxt;
  logic [TO_W-1:0]  tick_cnt, tick_nxt;
  logic             stable_hit, timeout_hit;
  logic [2:0]       pend_sel;
  logic             pend_to;

  pin_sync2 #(.WIDTH(5)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({mode_in, id_in}),
    .q     (sample)
  );

  // Registered tick: first asserted SAMPLE_DIV clocks after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      tick    <= 1'b0;
    end
  end

  // stable_cnt == 0 means no previous sample has been taken yet.
  always_comb begin
    stable_nxt = STB_W'(1);
    if ((stable_cnt != '0) && (sample == prev_sample)) begin
      stable_nxt = (stable_cnt == STB_LIMIT) ? stable_cnt : stable_cnt + STB_W'(1);
    end
    tick_nxt    = (tick_cnt == TO_LIMIT) ? tick_cnt : tick_cnt + TO_W'(1);
    stable_hit  = (stable_nxt == STB_LIMIT);
    timeout_hit = (tick_nxt == TO_LIMIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    busy      = 1'b1;
    state_dbg = state;
    case (state)
      ST_SETTLE: begin
        if (tick && (stable_hit || timeout_hit)) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        req_valid = 1'b1;
        if (req_ready) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy = 1'b0;
      end
      default: begin
        state_nxt = ST_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt  <= '0;
      tick_cnt    <= '0;
      prev_sample <= '0;
      pend_sel    <= IMG_UNKNOWN;
      pend_to     <= 1'b0;
      boot_sel    <= IMG_LOADER;
      boot_addr   <= 24'd0;
      timed_out   <= 1'b0;
    end else begin
      if ((state == ST_SETTLE) && tick) begin
        stable_cnt  <= stable_nxt;
        tick_cnt    <= tick_nxt;
        prev_sample <= sample;
        // A stable decode on the same tick as the timeout takes priority.
        if (stable_hit) begin
          pend_sel <= decode_pins(sample);
          pend_to  <= 1'b0;
        end else if (timeout_hit) begin
          pend_sel <= IMG_UNKNOWN;
          pend_to  <= 1'b1;
        end
      end
      if (state == ST_LATCH) begin
        boot_sel  <= pend_sel;
        boot_addr <= image_addr(pend_sel);
        timed_out <= pend_to;
      end
    end
  end

endmodule

// File: tb/tb_boot_target_select.sv
// Directed bench for boot_target_select with small prescaler/debounce/timeout parameters;
// expected requests are queued at stimulus time and compared when req_valid appears.
module tb_boot_target_select;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode_in = 1'b0;
  logic [3:0]  id_in = 4'd0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [2:0]  boot_sel;
  logic [23:0] boot_addr;
  logic        timed_out;
  logic        busy;
  logic [2:0]  state_dbg;

  typedef struct {
    logic [2:0]  sel;
    logic [23:0] addr;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  boot_target_select #(
    .SAMPLE_DIV(4), .STABLE_COUNT(3), .TIMEOUT_SAMPLES(10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode_in   (mode_in),
    .id_in     (id_in),
    .req_ready (req_ready),
    .req_valid (req_valid),
    .boot_sel  (boot_sel),
    .boot_addr (boot_addr),
    .timed_out (timed_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_pins(input logic [4:0] p);
    {mode_in, id_in} = p;
  endtask

  // Leaves the bench just after the release point; the next posedge is clock 1.
  task automatic reset_dut(input logic [4:0] p);
    reset = 1'b1;
    req_ready = 1'b0;
    set_pins(p);
    clk_n(2);
    reset = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] sel, input logic [23:0] addr, input logic to);
    exp_t e;
    e.sel = sel;
    e.addr = addr;
    e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic consume(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sel"}, 32'(boot_sel), 32'(e.sel));
      check({tag, "_addr"}, 32'(boot_addr), 32'(e.addr));
      check({tag, "_to"}, 32'(timed_out), 32'(e.to));
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < budget) begin
      clk_n(1);
      n++;
    end
    check({tag, "_valid"}, 32'(req_valid), 32'd1);
  endtask

  task automatic transfer(input string tag);
    req_ready = 1'b1;
    clk_n(1);
    req_ready = 1'b0;
    check({tag, "_vld_drop"}, 32'(req_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd3);
  endtask

  initial begin
    // Reset state
    reset_dut(5'b11110);
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(req_valid), 32'd0);
    check("rst_sel", 32'(boot_sel), 32'd0);
    check("rst_addr", 32'(boot_addr), 32'd0);
    check("rst_to", 32'(timed_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);

    // 1: 6502 adapter, exact latency
    reset_dut(5'b11110);
    push_exp(3'd2, 24'h0A8000, 1'b0);
    clk_n(13);
    check("t1_early", 32'(req_valid), 32'd0);
    clk_n(1);
    check("t1_valid14", 32'(req_valid), 32'd1);
    consume("t1");
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state", 32'(state_dbg), 32'd2);
    transfer("t1");

    // 2: Z80 with mode 0 and mode 1
    reset_dut(5'b01101);
    push_exp(3'd3, 24'h0FC000, 1'b0);
    wait_valid("t2a", 100);
    consume("t2a");
    transfer("t2a");
    reset_dut(5'b11101);
    push_exp(3'd3, 24'h0FC000, 1'b0);
    wait_valid("t2b", 100);
    consume("t2b");
    transfer("t2b");

    // 3: pins toggle every tick -> timeout fallback after tick 10
    reset_dut(5'b11110);
    push_exp(3'd1, 24'h054000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      set_pins((k % 2 == 0) ? 5'b11110 : 5'b11101);
      clk_n(4);
    end
    check("t3_early", 32'(req_valid), 32'd0);
    clk_n(2);
    check("t3_valid42", 32'(req_valid), 32'd1);
    consume("t3");
    transfer("t3");

    // 3b: stability reached on the same tick as timeout -> stable decode wins
    reset_dut(5'b01101);
    push_exp(3'd2, 24'h0A8000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      set_pins((k >= 7 || k % 2 == 1) ? 5'b11110 : 5'b01101);
      clk_n(4);
    end
    check("t3b_early", 32'(req_valid), 32'd0);
    clk_n(2);
    check("t3b_valid42", 32'(req_valid), 32'd1);
    consume("t3b");
    transfer("t3b");

    // 4: backpressure with pin changes, then transfer and terminal hold
    reset_dut(5'b11110);
    push_exp(3'd2, 24'h0A8000, 1'b0);
    wait_valid("t4", 100);
    for (int i = 0; i < 50; i++) begin
      set_pins(5'($urandom_range(0, 31)));
      clk_n(1);
      check("t4_hold_vld", 32'(req_valid), 32'd1);
      check("t4_hold_addr", 32'(boot_addr), 32'h0A8000);
    end
    consume("t4");
    transfer("t4");
    for (int i = 0; i < 10; i++) begin
      set_pins(5'($urandom_range(0, 31)));
      clk_n(1);
    end
    check("t4_done_state", 32'(state_dbg), 32'd3);
    check("t4_done_busy", 32'(busy), 32'd0);
    check("t4_done_vld", 32'(req_valid), 32'd0);
    check("t4_done_sel", 32'(boot_sel), 32'd2);
    check("t4_done_addr", 32'(boot_addr), 32'h0A8000);

    // 5: reset during REQUEST drops req_valid without a clock edge
    reset_dut(5'b11110);
    wait_valid("t5_pre", 100);
    reset = 1'b1;
    #1;
    check("t5_async_vld", 32'(req_valid), 32'd0);
    check("t5_async_state", 32'(state_dbg), 32'd0);
    check("t5_async_sel", 32'(boot_sel), 32'd0);
    reset_dut(5'b01110);
    push_exp(3'd4, 24'h150000, 1'b0);
    clk_n(13);
    check("t5_early", 32'(req_valid), 32'd0);
    clk_n(1);
    check("t5_valid14", 32'(req_valid), 32'd1);
    consume("t5");
    transfer("t5");

    // 6: one-tick glitch restarts the stability count
    reset_dut(5'b11110);
    push_exp(3'd2, 24'h0A8000, 1'b0);
    clk_n(8);
    set_pins(5'b00000);
    clk_n(4);
    set_pins(5'b11110);
    clk_n(13);
    check("t6_early", 32'(req_valid), 32'd0);
    clk_n(1);
    check("t6_valid26", 32'(req_valid), 32'd1);
    consume("t6");
    transfer("t6");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
